// File: rtl/ula_pkg.sv
// Shared types and opcode helpers for the sequential ALU: opcodes, FSM states,
// flag masks and the multi-cycle/illegal opcode classification.
package ula_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_ADDC = 5'b00001, OP_INC  = 5'b00011,
        OP_SUBB = 5'b00100, OP_SUB  = 5'b00101, OP_DEC  = 5'b00110,
        OP_SHL1 = 5'b01000, OP_SAR1 = 5'b01001, OP_SHR1 = 5'b01010,
        OP_SHLK = 5'b01011, OP_SARK = 5'b01100, OP_MUL  = 5'b01101,
        OP_ZERO = 5'b10000, OP_MOVB = 5'b10011, OP_UM   = 5'b11111
    } opcode_t;

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ITERA  = 1'b1
    } estado_t;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
        logic o;
    } mascara_flags_t;

    localparam mascara_flags_t MASCARA_NENHUMA = '{z: 1'b0, c: 1'b0, s: 1'b0, o: 1'b0};
    localparam mascara_flags_t MASCARA_ZS      = '{z: 1'b1, c: 1'b0, s: 1'b1, o: 1'b0};
    localparam mascara_flags_t MASCARA_ZCS     = '{z: 1'b1, c: 1'b1, s: 1'b1, o: 1'b0};
    localparam mascara_flags_t MASCARA_TODAS   = '{z: 1'b1, c: 1'b1, s: 1'b1, o: 1'b1};

    function automatic mascara_flags_t mascara_de(input logic [4:0] op);
        casez (op)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: mascara_de = MASCARA_TODAS;
            5'b01000, 5'b01001, 5'b01010,
            5'b01011, 5'b01100:           mascara_de = MASCARA_ZCS;
            5'b01101:                     mascara_de = MASCARA_TODAS;
            5'b1????:                     mascara_de = MASCARA_ZS;
            default:                      mascara_de = MASCARA_NENHUMA;
        endcase
    endfunction

    function automatic logic eh_multiciclo(input logic [4:0] op);
        eh_multiciclo = (op == OP_SHLK) || (op == OP_SARK) || (op == OP_MUL);
    endfunction

    function automatic logic eh_ilegal(input logic [4:0] op);
        eh_ilegal = (op == 5'b00010) || (op == 5'b00111) ||
                    (op == 5'b01110) || (op == 5'b01111);
    endfunction

endpackage

// File: rtl/ula_sequencial_if.sv
// Request/response bundle between the control unit / register file and the
// sequential ALU; master drives requests, slave is the ALU.
interface ula_sequencial_if #(parameter int LARGURA = 16);
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         controle;
    logic [LARGURA-1:0] operandoA;
    logic [LARGURA-1:0] operandoB;
    logic [LARGURA-1:0] resultadoOp;
    logic               out_valid;
    logic               erro;
    logic               Z, C, S, O;

    modport master (
        output in_valid, controle, operandoA, operandoB,
        input  in_ready, resultadoOp, out_valid, erro, Z, C, S, O
    );

    modport slave (
        input  in_valid, controle, operandoA, operandoB,
        output in_ready, resultadoOp, out_valid, erro, Z, C, S, O
    );
endinterface

// File: rtl/ula_nucleo_comb.sv
// Combinational single-cycle core: result plus carry/overflow candidates for
// arithmetic, one-bit shifts and the 16-function logic/move set.
module ula_nucleo_comb
    import ula_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic [4:0]         op_i,
    input  logic [LARGURA-1:0] a_i,
    input  logic [LARGURA-1:0] b_i,
    output logic [LARGURA-1:0] r_o,
    output logic               c_o,
    output logic               o_o
);
    localparam int W = LARGURA;

    logic [W-1:0] b_ef;
    logic         cin;
    logic [W:0]   soma;

    // Every arithmetic op is one adder: subtraction as A + ~B + cin, inc/dec with B=1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        b_ef = b_i;
        cin  = 1'b0;
        case (op_i)
            OP_ADDC: cin = 1'b1;
            OP_INC:  b_ef = W'(1);
            OP_SUBB: b_ef = ~b_i;
            OP_SUB:  begin b_ef = ~b_i;    cin = 1'b1; end
            OP_DEC:  begin b_ef = ~W'(1);  cin = 1'b1; end
            default: ;
        endcase
    end

    assign soma = {1'b0, a_i} + {1'b0, b_ef} + {{W{1'b0}}, cin};

    always_comb begin
        r_o = '0;
        c_o = soma[W];
        o_o = (a_i[W-1] == b_ef[W-1]) && (soma[W-1] != a_i[W-1]);
        casez (op_i)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: r_o = soma[W-1:0];
            5'b01000: begin r_o = {a_i[W-2:0], 1'b0};    c_o = a_i[W-1]; end
            5'b01001: begin r_o = {a_i[W-1], a_i[W-1:1]}; c_o = a_i[0];  end
            5'b01010: begin r_o = {1'b0, a_i[W-1:1]};    c_o = a_i[0];   end
            5'b1????: begin
                case (op_i[3:0])
                    4'h0: r_o = '0;
                    4'h1: r_o = a_i & b_i;
                    4'h2: r_o = ~a_i & b_i;
                    4'h3: r_o = b_i;
                    4'h4: r_o = a_i & ~b_i;
                    4'h5: r_o = a_i;
                    4'h6: r_o = a_i ^ b_i;
                    4'h7: r_o = a_i | b_i;
                    4'h8: r_o = ~a_i & ~b_i;
                    4'h9: r_o = ~(a_i ^ b_i);
                    4'hA: r_o = ~a_i;
                    4'hB: r_o = ~a_i | b_i;
                    4'hC: r_o = ~b_i;
                    4'hD: r_o = a_i | ~b_i;
                    4'hE: r_o = ~a_i | ~b_i;
                    default: r_o = '1;
                endcase
            end
            default: r_o = '0;
        endcase
    end
endmodule

// File: rtl/ula_sequencial.sv
// Clocked ALU: valid/ready accept, registered result and flag register, and an
// iterative datapath for variable shifts and shift-add unsigned multiply.
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_sequencial_if.slave  bus
);
    localparam int W   = LARGURA;
    localparam int SHW = $clog2(LARGURA);
    localparam int CW  = $clog2(LARGURA + 1);

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     op_q, op_d;
    logic [W-1:0]   acc_q, acc_d, mult_q, mult_d;
    logic [2*W-1:0] prod_q, prod_d, mcand_q, mcand_d;
    logic [W-1:0]   resultado_q, resultado_d;
    mascara_flags_t flags_q, flags_d;
    logic           out_valid_q, out_valid_d, erro_q, erro_d;

    logic [SHW-1:0] k;
    logic [W-1:0]   nuc_r, acc_prox, mult_prox;
    logic           nuc_c, nuc_o, desl_c;
    logic [2*W-1:0] prod_prox, mcand_prox;

    assign k = bus.operandoB[SHW-1:0];

    ula_nucleo_comb #(.LARGURA(W)) u_nucleo (
        .op_i (bus.controle),
        .a_i  (bus.operandoA),
        .b_i  (bus.operandoB),
        .r_o  (nuc_r),
        .c_o  (nuc_c),
        .o_o  (nuc_o)
    );

    // One iteration step: shift one bit, or one shift-add of the multiplier LSB.
    assign acc_prox   = (op_q == OP_SHLK) ? {acc_q[W-2:0], 1'b0} : {acc_q[W-1], acc_q[W-1:1]};
    assign desl_c     = (op_q == OP_SHLK) ? acc_q[W-1] : acc_q[0];
    assign prod_prox  = mult_q[0] ? (prod_q + mcand_q) : prod_q;
    assign mcand_prox = {mcand_q[2*W-2:0], 1'b0};
    assign mult_prox  = {1'b0, mult_q[W-1:1]};

    function automatic mascara_flags_t atualiza(input mascara_flags_t atual, input mascara_flags_t m,
                                                input logic [W-1:0] r, input logic c, input logic o);
        atualiza.z = m.z ? (r == '0) : atual.z;
        atualiza.c = m.c ? c         : atual.c;
        atualiza.s = m.s ? r[W-1]    : atual.s;
        atualiza.o = m.o ? o         : atual.o;
    endfunction

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        mult_d      = mult_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        resultado_d = resultado_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        erro_d      = 1'b0;
        case (estado_q)
            OCIOSO: if (bus.in_valid) begin
                if (eh_multiciclo(bus.controle) && (bus.controle == OP_MUL || k != '0)) begin
                    estado_d = ITERA;
                    op_d     = bus.controle;
                    acc_d    = bus.operandoA;
                    mult_d   = bus.operandoB;
                    prod_d   = '0;
                    mcand_d  = {{W{1'b0}}, bus.operandoA};
                    cnt_d    = (bus.controle == OP_MUL) ? CW'(W) : CW'(k);
                end else begin
                    out_valid_d = 1'b1;
                    if (eh_ilegal(bus.controle)) begin
                        erro_d      = 1'b1;
                        resultado_d = '0;
                    end else if (eh_multiciclo(bus.controle)) begin
                        // Zero-distance shift: nothing is shifted out, so carry is held.
                        resultado_d = bus.operandoA;
                        flags_d     = atualiza(flags_q, MASCARA_ZS, bus.operandoA, 1'b0, 1'b0);
                    end else begin
                        resultado_d = nuc_r;
                        flags_d     = atualiza(flags_q, mascara_de(bus.controle), nuc_r, nuc_c, nuc_o);
                    end
                end
            end
            ITERA: begin
                cnt_d   = cnt_q - 1'b1;
                acc_d   = acc_prox;
                mult_d  = mult_prox;
                prod_d  = prod_prox;
                mcand_d = mcand_prox;
                if (cnt_q == CW'(1)) begin
                    estado_d    = OCIOSO;
                    out_valid_d = 1'b1;
                    if (op_q == OP_MUL) begin
                        resultado_d = prod_prox[W-1:0];
                        flags_d     = atualiza(flags_q, MASCARA_TODAS, prod_prox[W-1:0],
                                               |prod_prox[2*W-1:W], |prod_prox[2*W-1:W]);
                    end else begin
                        resultado_d = acc_prox;
                        flags_d     = atualiza(flags_q, MASCARA_ZCS, acc_prox, desl_c, 1'b0);
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            mult_q      <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            resultado_q <= '0;
            flags_q     <= MASCARA_NENHUMA;
            out_valid_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            mult_q      <= mult_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            resultado_q <= resultado_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            erro_q      <= erro_d;
        end
    end

    assign bus.in_ready    = (estado_q == OCIOSO);
    assign bus.resultadoOp = resultado_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.erro        = erro_q;
    assign bus.Z           = flags_q.z;
    assign bus.C           = flags_q.c;
    assign bus.S           = flags_q.s;
    assign bus.O           = flags_q.o;
endmodule
